// File: rtl/brq_boot_imem_if.sv
// Bus bundle for the boot/instruction memory: boot byte stream handshake plus core fetch port.
// The master is the traffic source (UART RX and core fetch unit); the slave is brq_boot_imem.
interface brq_boot_imem_if #(
  parameter int AddrWidth = 15,
  parameter int HalfWord  = 16
);
  logic                 boot_byte_valid;
  logic [7:0]           boot_byte;
  logic                 boot_byte_ready;
  logic [AddrWidth-1:0] inst_mem_address;
  logic [HalfWord-1:0]  inst_mem_lsb;
  logic [HalfWord-1:0]  inst_mem_msb;

  modport master (
    output boot_byte_valid, boot_byte, inst_mem_address,
    input  boot_byte_ready, inst_mem_lsb, inst_mem_msb
  );

  modport slave (
    input  boot_byte_valid, boot_byte, inst_mem_address,
    output boot_byte_ready, inst_mem_lsb, inst_mem_msb
  );
endinterface

// File: rtl/brq_boot_imem.sv
// Two-bank instruction memory with a byte-stream boot loader that holds the core in reset
// until the program is loaded (or immediately releases it when booting is disabled).
module brq_boot_imem #(
  parameter int HalfWord     = 16,
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 15,
  parameter int MemDepthLog2 = 12
) (
  input  logic           brq_clk,
  input  logic           brq_rst,
  input  logic           boot_en,
  brq_boot_imem_if.slave bus,
  output logic           core_rst,
  output logic           boot_done,
  output logic           boot_error
);

  localparam int MemWords = 1 << MemDepthLog2;

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StRelease, StRun, StErr
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             nWords_q, nWords_d;
  logic [MemDepthLog2:0]   wordAddr_q, wordAddr_d;
  logic [1:0]              byteCnt_q, byteCnt_d;
  logic [23:0]             asmWord_q, asmWord_d;
  logic                    relCnt_q, relCnt_d;
  logic                    byteReady;
  logic                    wrEn;
  logic [DataWidth-1:0]    wrWord;
  logic [15:0]             nFull;
  logic [HalfWord-1:0]     lsb_q, msb_q;
  logic [HalfWord-1:0]     memLsb [MemWords];
  logic [HalfWord-1:0]     memMsb [MemWords];
  logic                    unusedAddrBits;

  assign nFull  = {bus.boot_byte, nWords_q[7:0]};
  assign wrWord = {bus.boot_byte, asmWord_q};
  // Only the low MemDepthLog2 address bits select a word; the rest alias.
  assign unusedAddrBits = ^bus.inst_mem_address;

  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state_q    <= StIdle;
      nWords_q   <= '0;
      wordAddr_q <= '0;
      byteCnt_q  <= '0;
      asmWord_q  <= '0;
      relCnt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      nWords_q   <= nWords_d;
      wordAddr_q <= wordAddr_d;
      byteCnt_q  <= byteCnt_d;
      asmWord_q  <= asmWord_d;
      relCnt_q   <= relCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nWords_d   = nWords_q;
    wordAddr_d = wordAddr_q;
    byteCnt_d  = byteCnt_q;
    asmWord_d  = asmWord_q;
    relCnt_d   = relCnt_q;
    byteReady  = 1'b0;
    wrEn       = 1'b0;
    core_rst   = 1'b1;
    boot_done  = 1'b0;
    boot_error = 1'b0;
    unique case (state_q)
      StIdle: begin
        relCnt_d = 1'b0;
        state_d  = boot_en ? StHdr0 : StRelease;
      end
      StHdr0: begin
        byteReady = 1'b1;
        if (bus.boot_byte_valid) begin
          nWords_d = {8'h00, bus.boot_byte};
          state_d  = StHdr1;
        end
      end
      StHdr1: begin
        byteReady = 1'b1;
        if (bus.boot_byte_valid) begin
          nWords_d   = nFull;
          wordAddr_d = '0;
          byteCnt_d  = '0;
          if (nFull == 16'd0 || 17'(nFull) > 17'(MemWords)) state_d = StErr;
          else                                              state_d = StData;
        end
      end
      StData: begin
        byteReady = 1'b1;
        if (bus.boot_byte_valid) begin
          asmWord_d = {bus.boot_byte, asmWord_q[23:8]};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            wrEn       = 1'b1;
            wordAddr_d = wordAddr_q + (MemDepthLog2+1)'(1);
            if (16'(wordAddr_q) == nWords_q - 16'd1) begin
              relCnt_d = 1'b0;
              state_d  = StRelease;
            end
          end
        end
      end
      // Two settle cycles so the final write lands before the core starts fetching.
      StRelease: begin
        if (relCnt_q) state_d = StRun;
        else          relCnt_d = 1'b1;
      end
      StRun: begin
        core_rst  = 1'b0;
        boot_done = 1'b1;
      end
      StErr: begin
        boot_error = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.boot_byte_ready = byteReady;

  always_ff @(posedge brq_clk) begin
    if (wrEn) begin
      memLsb[wordAddr_q[MemDepthLog2-1:0]] <= wrWord[HalfWord-1:0];
      memMsb[wordAddr_q[MemDepthLog2-1:0]] <= wrWord[DataWidth-1:HalfWord];
    end
  end

  // The core sees a NOP until it has been out of reset for a full cycle.
  always_ff @(posedge brq_clk) begin
    if (brq_rst || core_rst) begin
      lsb_q <= HalfWord'(16'h0013);
      msb_q <= '0;
    end else begin
      lsb_q <= memLsb[bus.inst_mem_address[MemDepthLog2-1:0]];
      msb_q <= memMsb[bus.inst_mem_address[MemDepthLog2-1:0]];
    end
  end

  assign bus.inst_mem_lsb = lsb_q;
  assign bus.inst_mem_msb = msb_q;

endmodule

// File: tb/tb_brq_boot_imem.sv
// Directed-sequence bench for brq_boot_imem with randomized payloads; a byte-stream level
// memory model predicts fetch data, release timing and error behaviour.
module tb_brq_boot_imem;

  logic brq_clk = 1'b0;
  logic brq_rst;
  logic boot_en;
  logic core_rst;
  logic boot_done;
  logic boot_error;

  brq_boot_imem_if bus ();

  brq_boot_imem dut (
    .brq_clk    (brq_clk),
    .brq_rst    (brq_rst),
    .boot_en    (boot_en),
    .bus        (bus),
    .core_rst   (core_rst),
    .boot_done  (boot_done),
    .boot_error (boot_error)
  );

  always #5 brq_clk = ~brq_clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] refMem [4096];
  logic [7:0]  stream [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic doReset(input bit en);
    bus.boot_byte_valid = 1'b0;
    boot_en = en;
    brq_rst = 1'b1;
    @(negedge brq_clk);
    @(negedge brq_clk);
    brq_rst = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, output bit ok);
    bit acc;
    bus.boot_byte_valid = 1'b0;
    repeat (gap) @(negedge brq_clk);
    bus.boot_byte_valid = 1'b1;
    bus.boot_byte = b;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      acc = bus.boot_byte_ready;
      @(negedge brq_clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.boot_byte_valid = 1'b0;
  endtask

  // gapMode: 0 back-to-back, 1 valid toggling every cycle, 2 random gaps; limit<0 sends all.
  task automatic applyStimulus(input int gapMode, input int limit);
    int  sent;
    int  total;
    int  gap;
    int  n;
    int  words;
    bit  ok;
    sent  = 0;
    total = (limit < 0) ? stream.size() : limit;
    for (int i = 0; i < total; i++) begin
      gap = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
      sendByte(stream[i], gap, ok);
      if (!ok) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL accept_timeout: byte %0d not accepted within 64 cycles, required acceptance", i);
        break;
      end
      sent++;
    end
    if (sent >= 2) begin
      n = int'({stream[1], stream[0]});
      if (n >= 1 && n <= 4096) begin
        words = (sent - 2) / 4;
        if (words > n) words = n;
        for (int w = 0; w < words; w++)
          refMem[w] = {stream[4*w+5], stream[4*w+4], stream[4*w+3], stream[4*w+2]};
      end
    end
  endtask

  task automatic buildRandom(input int n, input bit plantBeef);
    logic [31:0] w;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = (plantBeef && i == 5) ? 32'hDEADBEEF : $urandom();
      for (int k = 0; k < 4; k++) stream.push_back(8'(w >> (8*k)));
    end
  endtask

  task automatic buildDirected();
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  endtask

  task automatic checkRelease(input string tag);
    checkOutput({tag, "_rel1_rst"}, core_rst, 1);
    checkOutput({tag, "_rel1_ready"}, bus.boot_byte_ready, 0);
    @(negedge brq_clk);
    checkOutput({tag, "_rel2_rst"}, core_rst, 1);
    @(negedge brq_clk);
    checkOutput({tag, "_run_rst"}, core_rst, 0);
    checkOutput({tag, "_run_done"}, boot_done, 1);
  endtask

  task automatic checkFetch(input string tag, input logic [14:0] addr);
    logic [11:0] idx;
    idx = addr[11:0];
    bus.inst_mem_address = addr;
    @(negedge brq_clk);
    checkOutput(tag, {bus.inst_mem_msb, bus.inst_mem_lsb}, refMem[idx]);
  endtask

  initial begin
    int cnt;
    bus.boot_byte_valid  = 1'b0;
    bus.boot_byte        = '0;
    bus.inst_mem_address = '0;
    boot_en = 1'b1;
    brq_rst = 1'b1;
    @(negedge brq_clk);
    @(negedge brq_clk);
    checkOutput("rst_core_rst", core_rst, 1);
    checkOutput("rst_boot_done", boot_done, 0);
    checkOutput("rst_boot_error", boot_error, 0);
    checkOutput("rst_ready", bus.boot_byte_ready, 0);
    checkOutput("rst_nop", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'h0000_0013);
    brq_rst = 1'b0;
    checkOutput("idle_ready", bus.boot_byte_ready, 0);

    // Load 8 random words (word 5 = DEADBEEF) with random gaps.
    buildRandom(8, 1'b1);
    applyStimulus(2, -1);
    checkRelease("load8");
    checkFetch("load8_a0", 15'd0);
    checkFetch("load8_a7", 15'd7);

    // boot_en=0: run existing contents, count reset cycles and first-fetch latency.
    bus.inst_mem_address = 15'd5;
    doReset(1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!core_rst) break;
      checkOutput("noboot_nop", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'h0000_0013);
      checkOutput("noboot_ready", bus.boot_byte_ready, 0);
      cnt++;
      @(negedge brq_clk);
    end
    checkOutput("noboot_rst_cycles", cnt, 3);
    checkOutput("noboot_done", boot_done, 1);
    checkOutput("noboot_first_nop", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'h0000_0013);
    @(negedge brq_clk);
    checkOutput("noboot_beef", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'hDEADBEEF);
    checkFetch("noboot_a3", 15'd3);

    // Directed two-word program, back-to-back bytes.
    doReset(1'b1);
    buildDirected();
    applyStimulus(0, -1);
    checkRelease("dir");
    checkFetch("dir_a1", 15'd1);
    checkOutput("dir_a1_const", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'h0020_0593);
    checkFetch("dir_a0", 15'd0);
    checkOutput("dir_a0_const", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'h0010_0513);

    // Overwrite with random words, then reload the directed program with valid toggling.
    doReset(1'b1);
    buildRandom(2, 1'b0);
    applyStimulus(0, -1);
    checkRelease("rnd2");
    checkFetch("rnd2_a1", 15'd1);
    doReset(1'b1);
    buildDirected();
    applyStimulus(1, -1);
    checkRelease("tog");
    checkFetch("tog_a0", 15'd0);
    checkFetch("tog_a1", 15'd1);
    checkOutput("tog_a1_const", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'h0020_0593);

    // Illegal headers: N=0 and N=4097.
    doReset(1'b1);
    stream = '{8'h00, 8'h00};
    applyStimulus(0, -1);
    checkOutput("n0_error", boot_error, 1);
    checkOutput("n0_core_rst", core_rst, 1);
    checkOutput("n0_ready", bus.boot_byte_ready, 0);
    bus.boot_byte_valid = 1'b1;
    repeat (4) @(negedge brq_clk);
    checkOutput("n0_sticky", boot_error, 1);
    checkOutput("n0_not_done", boot_done, 0);
    doReset(1'b1);
    checkOutput("err_cleared", boot_error, 0);
    stream = '{8'h01, 8'h10};
    applyStimulus(0, -1);
    checkOutput("n4097_error", boot_error, 1);
    checkOutput("n4097_core_rst", core_rst, 1);

    // Abort mid-load after 6 payload bytes, then boot a single word.
    doReset(1'b1);
    buildRandom(2, 1'b0);
    applyStimulus(0, 8);
    doReset(1'b1);
    stream = '{8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    applyStimulus(2, -1);
    checkRelease("abort");
    checkFetch("abort_a0", 15'd0);
    checkOutput("abort_a0_const", {bus.inst_mem_msb, bus.inst_mem_lsb}, 32'h0000_006F);
    checkFetch("abort_a1_kept", 15'd1);

    // Full-depth load, then aliasing fetches.
    doReset(1'b1);
    buildRandom(4096, 1'b0);
    applyStimulus(0, -1);
    checkRelease("full");
    checkFetch("full_a4095", 15'd4095);
    checkFetch("full_alias0", 15'h1000);
    checkFetch("full_a0", 15'd0);
    checkFetch("full_alias_top", 15'h7FFF);
    for (int i = 0; i < 6; i++) checkFetch("full_rand", 15'($urandom()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/brq_boot_imem.md
Name: brq_boot_imem

Overview:
- Instruction-memory and boot-loader block directly upstream of the RV32IM core fetch port.
- Holds program memory as two 16-bit banks and drives the core's inst_mem_lsb/inst_mem_msb fetch inputs from inst_mem_address.
- Optionally loads the program at power-up from a byte stream such as a UART RX, keeping the core in reset until loading completes.

Parameters:
HalfWord, 16, width of each instruction bank
DataWidth, 32, instruction word width (2*HalfWord)
AddrWidth, 15, width of the core's inst_mem_address (word index)
MemDepthLog2, 12, log2 of implemented words (4096 words = 16 KiB); must be <= AddrWidth

Ports:
brq_clk  in  1  clock
brq_rst  in  1  synchronous active-high reset
boot_en  in  1  sampled in IDLE: 1 = load program from byte stream, 0 = run existing contents
boot_byte_valid  in  1  byte stream valid
boot_byte  in  8  byte stream data
boot_byte_ready  out  1  byte accepted when valid&ready
inst_mem_address  in  AddrWidth  fetch word index from core
inst_mem_lsb  out  HalfWord  instruction bits [15:0]
inst_mem_msb  out  HalfWord  instruction bits [31:16]
core_rst  out  1  active-high reset to core, synchronous to brq_clk
boot_done  out  1  high once core released
boot_error  out  1  high on illegal header; sticky until brq_rst

Behaviour:
- Reset values:
  - state=IDLE, core_rst=1, boot_done=0, boot_error=0, boot_byte_ready=0.
  - inst_mem_lsb=0x0013, inst_mem_msb=0x0000 (NOP, addi x0,x0,0).
  - Internal counters cleared. Memory contents are not cleared.
- Fetch path:
  - Registered read, 1-cycle latency: {msb,lsb} <= mem[inst_mem_address[MemDepthLog2-1:0]]. Upper address bits are ignored, so addresses alias.
  - While core_rst=1, outputs are forced to the NOP value instead of memory data.
- Byte stream protocol:
  - Header: 2 bytes, little-endian word count N.
  - Payload: N*4 bytes, each word little-endian (first byte -> bits [7:0]).
- FSM:
  - IDLE: exactly one cycle after reset. Next state is HDR0 if boot_en=1, else RELEASE.
  - HDR0: ready=1. On accept, N[7:0] <= byte; go to HDR1.
  - HDR1: ready=1. On accept, N[15:8] <= byte. Go to ERR if the full N==0 or N > 2**MemDepthLog2; else go to DATA with word_addr=0, byte_cnt=0.
  - DATA: ready=1.
    - Each accept shifts the byte into the word assembly register and increments byte_cnt (2 bits, wraps).
    - On the accept with byte_cnt==3: write the assembled word to both banks at word_addr in that same clock edge, and increment word_addr.
    - When the written word_addr == N-1, go to RELEASE.
  - RELEASE: ready=0; 2-cycle countdown with core_rst still 1 (lets the last write and the read pipeline settle), then go to RUN.
  - RUN: core_rst=0, boot_done=1, ready=0. Terminal until brq_rst.
  - ERR: core_rst=1, boot_error=1, ready=0. Terminal until brq_rst.
- Timing and boundary rules:
  - Bytes presented with valid=1 while ready=0 are not consumed.
  - valid may drop mid-word; assembly resumes with no byte lost.
  - core_rst deasserts on the cycle RUN is entered. The first fetch the core presents sees memory data one cycle later.
  - brq_rst asserted mid-load: FSM returns to IDLE and the partial word is discarded. Already-written words remain in memory.
  - Memory is single-port write / single-port read with no write-read collision concerns: reads are masked while core_rst=1, and writes only occur while core_rst=1.
  - N == 2**MemDepthLog2 is legal; word_addr has MemDepthLog2+1 bits, so no wrap-around before completion.

Test Plan:
- boot_en=0 after reset -> core_rst high for exactly 1 (IDLE) + 2 (RELEASE) cycles, then 0. boot_done=1, ready never 1. Preloaded mem[5]=0xDEADBEEF appears on {msb,lsb} one cycle after inst_mem_address=5.
- boot_en=1; stream 02 00 | 13 05 10 00 | 93 05 20 00 -> mem[0]=0x00100513 and mem[1]=0x00200593. core_rst falls 2 cycles after the last byte is accepted. Fetch address 1 -> msb=0x0020, lsb=0x0593.
- Same stream with valid toggling 1/0 every cycle -> identical memory contents and release. No byte dropped or duplicated.
- Header 00 00 -> boot_error=1, core_rst stays 1, ready=0. Header 01 10 (N=4097 at depth 4096) -> same error. brq_rst clears boot_error.
- brq_rst pulsed after 6 payload bytes, then a fresh boot with N=1, bytes 6F 00 00 00 -> mem[0]=0x0000006F. The partial second word is never written.
- N=4096 full load -> last word is written at address 4095, no wrap to 0, then release. Fetch address 0x1000 (aliases to 0) returns mem[0].
